led_blink_scheduler: RTL and testbench



---
 rtl/led_blink_scheduler.sv | 164 ++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_scheduler.sv
// Shares one LED among N_REQ requesters, each flashing an n-count blink code then a gap.
// Define LED_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module led_blink_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = 3200000,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] count,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic                   led_out
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_OF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_T  = (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
  localparam int unsigned TCK_W  = $clog2(MAX_T + 1);
  localparam int unsigned LAST_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_presc;
  logic [TCK_W-1:0] r_ticks;
  logic [CNT_W-1:0] r_remaining;
  logic [N_REQ-1:0] r_grant;
  logic             r_done;
  logic             r_led;
`ifndef LED_SCHED_FIXED_PRIO_EN
  logic [LAST_W-1:0] r_last;
`endif

  logic [N_REQ-1:0]  w_elig;
  logic              w_found;
  logic [LAST_W-1:0] w_win;
  logic [CNT_W-1:0]  w_win_cnt;
  logic [N_REQ-1:0]  w_win_1h;
  logic              w_tick;
  logic [TCK_W-1:0]  w_dur_m1;
  logic              w_last_tick;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_elig[i] = req[i] && (count[i*CNT_W +: CNT_W] != '0);
    end
  end

  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_win_cnt = '0;
`ifdef LED_SCHED_FIXED_PRIO_EN
    // Scanning downward lets the lowest eligible index overwrite the result last.
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_found   = 1'b1;
        w_win     = LAST_W'(k);
        w_win_cnt = count[k*CNT_W +: CNT_W];
      end
    end
`else
    for (int k = 0; k < int'(N_REQ); k++) begin
      int v_idx;
      v_idx = (int'(r_last) + 1 + k) % int'(N_REQ);
      if (!w_found && w_elig[v_idx]) begin
        w_found   = 1'b1;
        w_win     = LAST_W'(v_idx);
        w_win_cnt = count[v_idx*CNT_W +: CNT_W];
      end
    end
`endif
  end

  assign w_win_1h = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_tick   = (r_presc == PRE_W'(TICK_DIV - 1));

  always_comb begin
    w_dur_m1 = '0;
    case (r_state)
      S_ON:    w_dur_m1 = TCK_W'(ON_TICKS - 1);
      S_OFF:   w_dur_m1 = TCK_W'(OFF_TICKS - 1);
      S_GAP:   w_dur_m1 = TCK_W'(GAP_TICKS - 1);
      default: w_dur_m1 = '0;
    endcase
  end

  assign w_last_tick = w_tick && (r_ticks == w_dur_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_ticks     <= '0;
      r_remaining <= '0;
      r_grant     <= '0;
      r_done      <= 1'b0;
      r_led       <= 1'b0;
`ifndef LED_SCHED_FIXED_PRIO_EN
      r_last      <= LAST_W'(N_REQ - 1);
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_state     <= S_ON;
          r_remaining <= w_win_cnt;
          r_grant     <= w_win_1h;
          r_presc     <= '0;
          r_ticks     <= '0;
          r_led       <= 1'b1;
`ifndef LED_SCHED_FIXED_PRIO_EN
          r_last      <= w_win;
`endif
        end
      end else if (!w_tick) begin
        r_presc <= r_presc + PRE_W'(1);
      end else if (!w_last_tick) begin
        r_presc <= '0;
        r_ticks <= r_ticks + TCK_W'(1);
      end else begin
        // Final tick of the current state: every transition re-enters with cleared counters.
        r_presc <= '0;
        r_ticks <= '0;
        case (r_state)
          S_ON: begin
            r_state <= S_OFF;
            r_led   <= 1'b0;
          end
          S_OFF: begin
            if (r_remaining > CNT_W'(1)) begin
              r_remaining <= r_remaining - CNT_W'(1);
              r_state     <= S_ON;
              r_led       <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign led_out = r_led;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with short ticks (TICK_DIV=2).
// Honours LED_SCHED_FIXED_PRIO_EN when choosing the expected grant order.
module tb_led_blink_scheduler;

  localparam int NR   = 4;
  localparam int CW   = 4;
  localparam int TD   = 2;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int GAPT = 8;
  localparam int PER  = (ONT + OFFT) * TD;
  localparam int HI   = ONT * TD;
  localparam int GAPC = GAPT * TD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*CW-1:0] count = '0;
  logic [NR-1:0] grant;
  logic          busy;
  logic          done;
  logic          led_out;

  int n_total = 0;
  int n_bad   = 0;

  led_blink_scheduler #(
    .N_REQ(NR), .CNT_W(CW), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .count(count),
    .grant(grant), .busy(busy), .done(done), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first granted cycle; returns in the done cycle (or after the budget).
  task automatic watch_code(input string tag, input logic [NR-1:0] g, input int n,
                            input int drop_at);
    int   len;
    int   done_at;
    int   bad_led;
    int   bad_gb;
    logic exp_led;
    len     = n * PER + GAPC;
    done_at = -1;
    bad_led = 0;
    bad_gb  = 0;
    for (int j = 0; j < 400; j++) begin
      if (done_at < 0) begin
        if (done === 1'b1) begin
          done_at = j;
        end else begin
          if (j == drop_at) begin
            req   = '0;
            count = '0;
          end
          exp_led = (j < n * PER) && ((j % PER) < HI);
          if (led_out !== exp_led) bad_led++;
          if (grant !== g || busy !== 1'b1) bad_gb++;
          step();
        end
      end
    end
    check_eq({tag, "_len"}, done_at, len);
    check_eq({tag, "_grant_busy"}, bad_gb, 0);
    check_eq({tag, "_led"}, bad_led, 0);
    check_eq({tag, "_end_grant"}, grant, '0);
    check_eq({tag, "_end_busy"}, busy, 1'b0);
  endtask

  logic [NR-1:0] rr_exp  [5];
  logic [NR-1:0] alt_exp [3];
  int            seen;

  initial begin
`ifdef LED_SCHED_FIXED_PRIO_EN
    rr_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    alt_exp = '{4'b0010, 4'b0010, 4'b0010};
`else
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    alt_exp = '{4'b0010, 4'b1000, 4'b0010};
`endif

    rst = 1'b1;
    step();
    step();
    check_eq("rst_grant", grant, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_led", led_out, 1'b0);
    rst = 1'b0;

    // Single code, requester 1, count 3; request dropped right after the grant.
    req   = 4'b0010;
    count = 16'h0030;
    step();
    check_eq("single_grant0", grant, 4'b0010);
    check_eq("single_busy0", busy, 1'b1);
    check_eq("single_led0", led_out, 1'b1);
    watch_code("single", 4'b0010, 3, 1);
    step();
    check_eq("single_done_once", done, 1'b0);
    check_eq("single_idle_grant", grant, '0);

    // Zero count is never granted.
    req   = 4'b0100;
    count = 16'h0000;
    seen  = 0;
    repeat (12) begin
      step();
      if (grant !== '0 || busy !== 1'b0 || led_out !== 1'b0) seen++;
    end
    check_eq("zero_cnt", seen, 0);

    // Round-robin with all four requesting count 1.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    req   = 4'b1111;
    count = 16'h1111;
    step();
    for (int i = 0; i < 5; i++) begin
      watch_code($sformatf("rr%0d", i), rr_exp[i], 1, -1);
      if (i < 4) step();
    end

    // Request dropped mid-code still completes the full code.
    req   = 4'b0001;
    count = 16'h0002;
    step();
    check_eq("drop_grant0", grant, 4'b0001);
    watch_code("drop", 4'b0001, 2, 10);

    // Reset during ON abandons the code and restores requester-0 priority.
    req   = 4'b0100;
    count = 16'h0500;
    step();
    check_eq("rstmid_grant0", grant, 4'b0100);
    step();
    step();
    rst   = 1'b1;
    req   = 4'b1001;
    count = 16'h1001;
    step();
    check_eq("rstmid_led", led_out, 1'b0);
    check_eq("rstmid_grant", grant, '0);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_done", done, 1'b0);
    rst = 1'b0;
    step();
    check_eq("rstmid_prio0", grant, 4'b0001);

    // Maximum count sequences all 15 flashes.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    req   = 4'b1000;
    count = 16'hF000;
    step();
    check_eq("maxcnt_grant0", grant, 4'b1000);
    watch_code("maxcnt", 4'b1000, 15, 0);

    // Requesters 1 and 3 held: alternate under round-robin, always 1 under fixed priority.
    req   = 4'b1010;
    count = 16'h1010;
    step();
    for (int i = 0; i < 3; i++) begin
      watch_code($sformatf("alt%0d", i), alt_exp[i], 1, -1);
      if (i < 2) step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
